// File: rtl/dbi_lane_fifo_if.sv
// dbi_lane_fifo_if: write/read/statistics bundle for the multi-lane DBI FIFO
interface dbi_lane_fifo_if #(
  parameter int LANES = 8,
  parameter int BW = 16,
  parameter int CNT_BW = 32
);
  logic dbi_en;
  logic dbi_mode;
  logic wr;
  logic [LANES*BW-1:0] in;
  logic o_full;
  logic rd;
  logic [LANES*BW-1:0] out;
  logic o_valid;
  logic o_empty;
  logic clear_stats;
  logic [CNT_BW-1:0] raw_toggles;
  logic [CNT_BW-1:0] enc_toggles;
  modport master (
    output dbi_en, dbi_mode, wr, in, rd, clear_stats,
    input o_full, out, o_valid, o_empty, raw_toggles, enc_toggles
  );
  modport slave (
    input dbi_en, dbi_mode, wr, in, rd, clear_stats,
    output o_full, out, o_valid, o_empty, raw_toggles, enc_toggles
  );
endinterface

// File: rtl/dbi_lane_fifo.sv
// dbi_lane_fifo: per-lane DC/AC data-bus-inversion FIFO with raw/encoded toggle statistics
module dbi_lane_fifo #(
  parameter int LANES = 8,
  parameter int BW = 16,
  parameter int DEPTH = 16,
  parameter int CNT_BW = 32
) (
  input logic clk,
  input logic reset,
  dbi_lane_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = BW + 1;
  localparam int SW = $clog2(LANES*EW + 1);
  localparam int XW = (CNT_BW > SW ? CNT_BW : SW) + 1;
  localparam logic [CNT_BW-1:0] MAX = '1;
  logic [AW:0] wp, rp;
  logic [LANES-1:0][EW-1:0] mem [DEPTH];
  logic [LANES-1:0][EW-1:0] ac_ref, enc_w, rd_w;
  logic [LANES-1:0][BW-1:0] raw_ref, dec_w;
  logic [SW-1:0] raw_t [LANES];
  logic [SW-1:0] enc_t [LANES];
  logic [SW-1:0] raw_sum, enc_sum;
  logic [CNT_BW-1:0] raw_cnt, enc_cnt;
  logic rd_acc, wr_acc;
  assign bus.o_empty = wp == rp;
  assign bus.o_full = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign rd_acc = bus.rd && !bus.o_empty;
  assign wr_acc = bus.wr && (!bus.o_full || rd_acc);
  assign rd_w = mem[rp[AW-1:0]];
  assign bus.raw_toggles = raw_cnt;
  assign bus.enc_toggles = enc_cnt;
  // AC compares against the previous stored (encoded) word, DC against the word alone
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [BW-1:0] d, cmp;
    logic flag;
    assign d = bus.in[BW*i +: BW];
    assign cmp = bus.dbi_mode ? d ^ ac_ref[i][BW-1:0] : d;
    assign flag = bus.dbi_en && ($countones(cmp) > BW/2);
    assign enc_w[i] = {flag, flag ? ~d : d};
    assign dec_w[i] = rd_w[i][BW-1:0] ^ {BW{rd_w[i][BW]}};
    assign raw_t[i] = SW'($countones(d ^ raw_ref[i]));
    assign enc_t[i] = SW'($countones(enc_w[i] ^ ac_ref[i]));
  end
  always_comb begin
    raw_sum = '0;
    enc_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      raw_sum = raw_sum + raw_t[i];
      enc_sum = enc_sum + enc_t[i];
    end
  end
  function automatic logic [CNT_BW-1:0] sat_add(logic [CNT_BW-1:0] a, logic [SW-1:0] b);
    logic [XW-1:0] s;
    s = XW'(a) + XW'(b);
    return s > XW'(MAX) ? MAX : s[CNT_BW-1:0];
  endfunction
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wp[AW-1:0]] <= enc_w;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      bus.out <= '0;
      bus.o_valid <= 1'b0;
      raw_cnt <= '0;
      enc_cnt <= '0;
      ac_ref <= '0;
      raw_ref <= '0;
    end else begin
      bus.o_valid <= rd_acc;
      if (rd_acc) begin
        rp <= rp + (AW+1)'(1);
        bus.out <= dec_w;
      end
      if (wr_acc) begin
        wp <= wp + (AW+1)'(1);
        ac_ref <= enc_w;
        raw_ref <= bus.in;
      end
      raw_cnt <= bus.clear_stats ? '0 : wr_acc ? sat_add(raw_cnt, raw_sum) : raw_cnt;
      enc_cnt <= bus.clear_stats ? '0 : wr_acc ? sat_add(enc_cnt, enc_sum) : enc_cnt;
    end
  end
endmodule
